// File: rtl/digit_scan_mux.sv
// digit_scan_mux
//   Time-multiplexes NUM_DIGITS BCD digits onto one 7-segment decoder and a
//   common-anode digit bank. Each digit gets a slot of REFRESH_CYCLES clocks:
//   the first BLANK_CYCLES of the slot keep every anode off (anti-ghosting),
//   the rest enable the slot's digit if it is displayable. The digit value is
//   captured into a shadow register once per frame so mid-frame changes on
//   digits_in never tear the display.
//
//   Interface timing: there is no valid/ready handshake. num, anode and
//   frame_done are registered and meaningful on every cycle. num follows the
//   scan slot with no lag, while anode lags the internal enable by one clock
//   so it switches in the same cycle as the downstream decoder's registered
//   segment output.
//
// Ports
//   clk         in   1              rising-edge clock
//   rst         in   1              synchronous reset, active-high
//   digits_in   in   4*NUM_DIGITS   BCD digits; [3:0] = digit 0 (least significant)
//   num         out  4              digit value to decoder; always 0..9
//   anode       out  NUM_DIGITS     active-low digit enables; bit i = digit i
//   frame_done  out  1              1-cycle pulse at end of each full scan
module digit_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter bit LZ_BLANK       = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  output logic [3:0]                num,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic                      frame_done
);

  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int SW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_CYCLES - 1);
  localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [SW-1:0]             sel;
  logic [4*NUM_DIGITS-1:0]   shadow;

  logic                      end_show;
  logic                      frame_wrap;
  logic [SW-1:0]             sel_nxt;
  logic [4*NUM_DIGITS-1:0]   shadow_nxt;
  logic                      cur_visible;
  logic [3:0]                nxt_digit;

  // A digit is displayable when it is valid BCD and, with leading-zero
  // suppression on, it is digit 0 or some digit at or above it is nonzero.
  function automatic logic digit_visible(input logic [SW-1:0] s,
                                         input logic [4*NUM_DIGITS-1:0] sh);
    logic [3:0] d;
    logic       upper_nonzero;
    d = sh[4*int'(s) +: 4];
    upper_nonzero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(s) && sh[4*i +: 4] != 4'd0) upper_nonzero = 1'b1;
    end
    digit_visible = (d <= 4'd9) &&
                    (!LZ_BLANK || s == '0 || upper_nonzero);
  endfunction

  // Hidden digits drive 0 so the decoder never sees a non-BCD value.
  function automatic logic [3:0] shown_digit(input logic [SW-1:0] s,
                                             input logic [4*NUM_DIGITS-1:0] sh);
    shown_digit = digit_visible(s, sh) ? sh[4*int'(s) +: 4] : 4'd0;
  endfunction

  assign end_show   = (state == ST_SHOW) && (cnt == SLOT_LAST);
  assign frame_wrap = end_show && (sel == SEL_LAST);

  // Next slot selection and snapshot, so num can be loaded with the new
  // slot's value on the very edge the slot begins.
  always_comb begin
    sel_nxt    = sel;
    shadow_nxt = shadow;
    if (end_show) begin
      sel_nxt = frame_wrap ? '0 : sel + 1'b1;
      if (frame_wrap) shadow_nxt = digits_in;
    end
  end

  assign cur_visible = digit_visible(sel, shadow);
  assign nxt_digit   = shown_digit(sel_nxt, shadow_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      sel        <= '0;
      shadow     <= '0;
      num        <= 4'd0;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (cnt == BLANK_LAST) state <= ST_SHOW;
          cnt <= cnt + 1'b1;
        end
        ST_SHOW: begin
          if (end_show) begin
            state <= ST_BLANK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
        end
      endcase
      sel        <= sel_nxt;
      shadow     <= shadow_nxt;
      frame_done <= frame_wrap;
      num        <= nxt_digit;
      // Enable for this cycle, presented on anode one clock later.
      anode      <= (state == ST_SHOW && cur_visible) ? ~(AN_ONE << sel) : '1;
    end
  end

endmodule

// File: tb/tb_digit_scan_mux.sv
module tb_digit_scan_mux;

  localparam int ND    = 4;
  localparam int R     = 8;
  localparam int B     = 2;
  localparam int FRAME = ND * R;
  localparam int W     = 18;

  logic          clk;
  logic          rst;
  logic [15:0]   digits_in;
  logic [3:0]    num1, num0;
  logic [3:0]    anode1, anode0;
  logic          fd1, fd0;

  logic [W-1:0]  exp_q[$];
  int            n_tests;
  int            n_fail;
  int            t;
  logic [15:0]   snap;
  int            exp_fd_count;
  int            dut_fd_count;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  digit_scan_mux #(.NUM_DIGITS(ND), .REFRESH_CYCLES(R), .BLANK_CYCLES(B),
                   .LZ_BLANK(1'b1)) dut1 (
    .clk(clk), .rst(rst), .digits_in(digits_in),
    .num(num1), .anode(anode1), .frame_done(fd1)
  );

  digit_scan_mux #(.NUM_DIGITS(ND), .REFRESH_CYCLES(R), .BLANK_CYCLES(B),
                   .LZ_BLANK(1'b0)) dut0 (
    .clk(clk), .rst(rst), .digits_in(digits_in),
    .num(num0), .anode(anode0), .frame_done(fd0)
  );

  // Reference: a digit is lit when it is BCD and (no suppression, or it is
  // digit 0, or it is not above the most significant nonzero nibble).
  function automatic bit ref_visible(input int s, input logic [15:0] sh, input bit lz);
    int         hi;
    logic [3:0] d;
    hi = -1;
    for (int i = 0; i < ND; i++) if (sh[4*i +: 4] != 4'd0) hi = i;
    d = sh[4*s +: 4];
    return (d <= 4'd9) && (!lz || s == 0 || s <= hi);
  endfunction

  function automatic logic [3:0] ref_num(input int s, input logic [15:0] sh, input bit lz);
    return ref_visible(s, sh, lz) ? sh[4*s +: 4] : 4'd0;
  endfunction

  function automatic logic [3:0] ref_anode(input int tt, input logic [15:0] sh, input bit lz);
    int s;
    logic [3:0] an;
    s  = (tt / R) % ND;
    an = 4'hF;
    if ((tt % R) >= B && ref_visible(s, sh, lz)) an[s] = 1'b0;
    return an;
  endfunction

  // Model of one clock edge: t counts cycles since the last reset edge, snap is
  // the frame's snapshot. The expectation for the new cycle is queued.
  task automatic model_edge(input logic r, input logic [15:0] d);
    logic [3:0] an1, an0, n1, n0;
    logic       fd;
    int         s;
    if (r) begin
      t    = 0;
      snap = 16'h0;
      an1  = 4'hF;
      an0  = 4'hF;
    end else begin
      an1 = ref_anode(t, snap, 1'b1);
      an0 = ref_anode(t, snap, 1'b0);
      if ((t + 1) % FRAME == 0) snap = d;
      t++;
    end
    s  = (t / R) % ND;
    n1 = ref_num(s, snap, 1'b1);
    n0 = ref_num(s, snap, 1'b0);
    fd = (t != 0) && (t % FRAME == 0);
    if (fd) exp_fd_count++;
    exp_q.push_back({fd, an1, n1, fd, an0, n0});
  endtask

  // driver tasks
  task automatic step(input logic r, input logic [15:0] d);
    rst       = r;
    digits_in = d;
    @(posedge clk);
    #1;
    model_edge(r, d);
  endtask

  task automatic run(input int cycles, input logic [15:0] d);
    for (int i = 0; i < cycles; i++) step(1'b0, d);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < ND; i++) begin
      case ($urandom_range(0, 3))
        0:       v[4*i +: 4] = 4'd0;
        1:       v[4*i +: 4] = 4'($urandom_range(10, 15));
        default: v[4*i +: 4] = 4'($urandom_range(0, 9));
      endcase
    end
    return v;
  endfunction

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (fd1) dut_fd_count++;
        n_tests++;
        if ({fd1, anode1, num1} !== e[17:9]) begin
          n_fail++;
          $display("FAIL lz1_out t=%0d got fd=%b an=%b num=%0d want fd=%b an=%b num=%0d",
                   t, fd1, anode1, num1, e[17], e[16:13], e[12:9]);
        end
        n_tests++;
        if ({fd0, anode0, num0} !== e[8:0]) begin
          n_fail++;
          $display("FAIL lz0_out t=%0d got fd=%b an=%b num=%0d want fd=%b an=%b num=%0d",
                   t, fd0, anode0, num0, e[8], e[7:4], e[3:0]);
        end
        n_tests++;
        if (num1 > 4'd9 || num0 > 4'd9) begin
          n_fail++;
          $display("FAIL num_range got num1=%0d num0=%0d want <=9", num1, num0);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [15:0] d;
    n_tests      = 0;
    n_fail       = 0;
    t            = 0;
    snap         = 16'h0;
    exp_fd_count = 0;
    dut_fd_count = 0;

    // reset for 3 cycles; first frame shows only digit 0 = 0
    for (int i = 0; i < 3; i++) step(1'b1, 16'h4321);
    run(FRAME, 16'h4321);
    run(2 * FRAME, 16'h4321);

    // leading zeros, then an invalid nibble
    run(2 * FRAME, 16'h0070);
    run(2 * FRAME, 16'h12A4);
    run(FRAME, 16'h0000);

    // mid-frame change must not tear
    run(FRAME, 16'h1111);
    run(10, 16'h1111);
    run(2 * FRAME + 5, 16'h2222);

    // reset during the SHOW phase of digit 2
    while (!(((t / R) % ND) == 2 && (t % R) >= B + 2)) step(1'b0, 16'h9876);
    step(1'b1, 16'h9876);
    run(2 * FRAME, 16'h9876);

    // randomized traffic with mid-frame changes and occasional resets
    d = rand_digits();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) d = rand_digits();
      step($urandom_range(0, 199) == 0, d);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d left want 0", exp_q.size());
    end
    n_tests++;
    if (dut_fd_count != exp_fd_count) begin
      n_fail++;
      $display("FAIL fd_count got %0d want %0d", dut_fd_count, exp_fd_count);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
